// File: rtl/bus_cycle_ctrl.sv
// bus_cycle_ctrl: 68000 bus-cycle sequencer for the Mackerel-10 system controller.
// Generates DTACK after per-region wait states, raises BERR on timeout or spurious
// IACK, runs DUART vectored / EXP autovectored IACK cycles, and encodes IPL.
module bus_cycle_ctrl #(
  parameter int ROM_WS      = 2,
  parameter int RAM_WS      = 0,
  parameter int IO_WS       = 3,
  parameter int TIMEOUT     = 64,
  parameter int DUART_LEVEL = 5,
  parameter int EXP_LEVEL   = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       AS,
  input  logic       UDS,
  input  logic       LDS,
  input  logic [2:0] FC,
  input  logic [3:0] ADDR_H,
  input  logic [2:0] ADDR_L,
  input  logic       IRQ_DUART,
  input  logic       IRQ_EXP,
  output logic       DTACK,
  output logic       BERR,
  output logic       VPA,
  output logic       IACK_DUART,
  output logic [2:0] IPL,
  output logic       TIMEOUT_FLAG
);

  localparam int WS_W = 8;
  localparam int TO_W = $clog2(TIMEOUT + 1);

  localparam logic [WS_W-1:0] ROM_WS_V  = WS_W'(ROM_WS);
  localparam logic [WS_W-1:0] RAM_WS_V  = WS_W'(RAM_WS);
  localparam logic [WS_W-1:0] IO_WS_V   = WS_W'(IO_WS);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [2:0]      DUART_LVL = 3'(DUART_LEVEL);
  localparam logic [2:0]      EXP_LVL   = 3'(EXP_LEVEL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACK,
    S_FAULT,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [WS_W-1:0] ws_cnt_q, ws_cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            ack_src_q, ack_src_d;
  logic            dtack_q, dtack_d;
  logic            berr_q, berr_d;
  logic            vpa_q, vpa_d;
  logic            iack_q, iack_d;
  logic            flag_q, flag_d;
  logic            irq_d_s1_q, irq_d_s1_d;
  logic            irq_d_s2_q, irq_d_s2_d;
  logic            irq_e_s1_q, irq_e_s1_d;
  logic            irq_e_s2_q, irq_e_s2_d;
  logic [2:0]      ipl_q, ipl_d;
  logic [2:0]      lvl_duart, lvl_exp, lvl_max;
  logic            cycle_start;

  assign DTACK        = dtack_q;
  assign BERR         = berr_q;
  assign VPA          = vpa_q;
  assign IACK_DUART   = iack_q;
  assign IPL          = ipl_q;
  assign TIMEOUT_FLAG = flag_q;

  // Next-state logic: interrupt synchroniser/encoder and the bus-cycle sequencer
  always_comb begin
    state_d    = state_q;
    ws_cnt_d   = ws_cnt_q;
    to_cnt_d   = to_cnt_q;
    ack_src_d  = ack_src_q;
    dtack_d    = dtack_q;
    berr_d     = berr_q;
    vpa_d      = vpa_q;
    iack_d     = iack_q;
    flag_d     = flag_q;

    irq_d_s1_d = IRQ_DUART;
    irq_d_s2_d = irq_d_s1_q;
    irq_e_s1_d = IRQ_EXP;
    irq_e_s2_d = irq_e_s1_q;

    lvl_duart  = irq_d_s2_q ? 3'd0 : DUART_LVL;
    lvl_exp    = irq_e_s2_q ? 3'd0 : EXP_LVL;
    lvl_max    = (lvl_duart > lvl_exp) ? lvl_duart : lvl_exp;
    ipl_d      = ~lvl_max;

    cycle_start = !AS && (!UDS || !LDS || (FC == 3'b111));

    case (state_q)
      S_IDLE: begin
        if (cycle_start) begin
          to_cnt_d  = '0;
          ws_cnt_d  = '0;
          ack_src_d = 1'b0;
          state_d   = S_WAIT;
          if (FC == 3'b111) begin
            if (ADDR_L == DUART_LVL) begin
              ws_cnt_d  = IO_WS_V;
              ack_src_d = 1'b1;
              iack_d    = 1'b0;
            end else if (ADDR_L == EXP_LVL) begin
              vpa_d   = 1'b0;
              state_d = S_ACK;
            end else begin
              berr_d  = 1'b0;
              state_d = S_FAULT;
            end
          end else if (ADDR_H == 4'h0) begin
            ws_cnt_d  = ROM_WS_V;
            ack_src_d = 1'b1;
          end else if (ADDR_H[3:2] == 2'b10) begin
            ws_cnt_d  = RAM_WS_V;
            ack_src_d = 1'b1;
          end else if (ADDR_H[3:2] == 2'b11) begin
            ws_cnt_d  = IO_WS_V;
            ack_src_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (AS) begin
          dtack_d = 1'b1;
          berr_d  = 1'b1;
          vpa_d   = 1'b1;
          iack_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
          if (ack_src_q && (ws_cnt_q == '0)) begin
            dtack_d = 1'b0;
            state_d = S_ACK;
          end else if (to_cnt_q == TO_LAST) begin
            berr_d  = 1'b0;
            flag_d  = 1'b1;
            state_d = S_FAULT;
          end else if (ws_cnt_q != '0) begin
            ws_cnt_d = ws_cnt_q - 1'b1;
          end
        end
      end
      S_ACK, S_FAULT: begin
        if (AS) begin
          dtack_d = 1'b1;
          berr_d  = 1'b1;
          vpa_d   = 1'b1;
          iack_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        if (AS) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_DONE;
      end
    endcase
  end

  // Register every flop; reset parks in DONE so a half-seen cycle is never acked
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= S_DONE;
      ws_cnt_q   <= '0;
      to_cnt_q   <= '0;
      ack_src_q  <= 1'b0;
      dtack_q    <= 1'b1;
      berr_q     <= 1'b1;
      vpa_q      <= 1'b1;
      iack_q     <= 1'b1;
      flag_q     <= 1'b0;
      irq_d_s1_q <= 1'b1;
      irq_d_s2_q <= 1'b1;
      irq_e_s1_q <= 1'b1;
      irq_e_s2_q <= 1'b1;
      ipl_q      <= 3'b111;
    end else begin
      state_q    <= state_d;
      ws_cnt_q   <= ws_cnt_d;
      to_cnt_q   <= to_cnt_d;
      ack_src_q  <= ack_src_d;
      dtack_q    <= dtack_d;
      berr_q     <= berr_d;
      vpa_q      <= vpa_d;
      iack_q     <= iack_d;
      flag_q     <= flag_d;
      irq_d_s1_q <= irq_d_s1_d;
      irq_d_s2_q <= irq_d_s2_d;
      irq_e_s1_q <= irq_e_s1_d;
      irq_e_s2_q <= irq_e_s2_d;
      ipl_q      <= ipl_d;
    end
  end

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// tb_bus_cycle_ctrl: directed vectors for the bus-cycle sequencer, one row per clock
// edge, plus hand-written sequences for bus-error timeout and mid-cycle reset.
module tb_bus_cycle_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       AS, UDS, LDS;
  logic [2:0] FC;
  logic [3:0] ADDR_H;
  logic [2:0] ADDR_L;
  logic       IRQ_DUART, IRQ_EXP;
  logic       DTACK, BERR, VPA, IACK_DUART;
  logic [2:0] IPL;
  logic       TIMEOUT_FLAG;

  int total = 0;
  int bad   = 0;

  // Expected output word: {DTACK, BERR, VPA, IACK_DUART, IPL[2:0], TIMEOUT_FLAG}
  localparam logic [7:0] OFF = 8'b1111_1110;

  typedef struct packed {
    logic       as_n;
    logic       uds_n;
    logic       lds_n;
    logic [2:0] fc;
    logic [3:0] addr_h;
    logic [2:0] addr_l;
    logic       irq_d;
    logic       irq_e;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  bus_cycle_ctrl dut (
    .CLK          (CLK),
    .RST          (RST),
    .AS           (AS),
    .UDS          (UDS),
    .LDS          (LDS),
    .FC           (FC),
    .ADDR_H       (ADDR_H),
    .ADDR_L       (ADDR_L),
    .IRQ_DUART    (IRQ_DUART),
    .IRQ_EXP      (IRQ_EXP),
    .DTACK        (DTACK),
    .BERR         (BERR),
    .VPA          (VPA),
    .IACK_DUART   (IACK_DUART),
    .IPL          (IPL),
    .TIMEOUT_FLAG (TIMEOUT_FLAG)
  );

  // Free-running CPU clock
  always #5 CLK = ~CLK;

  // Safety net so the run always terminates
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] eo(input logic d, input logic b, input logic v,
                                    input logic i, input logic [2:0] ipl, input logic f);
    return {d, b, v, i, ipl, f};
  endfunction

  function automatic vec_t busV(input logic as_n, input logic uds_n, input logic lds_n,
                                input logic [2:0] fc, input logic [3:0] ah,
                                input logic [2:0] al, input logic [7:0] e);
    vec_t v;
    v.as_n = as_n; v.uds_n = uds_n; v.lds_n = lds_n; v.fc = fc;
    v.addr_h = ah; v.addr_l = al; v.irq_d = 1'b1; v.irq_e = 1'b1; v.exp = e;
    return v;
  endfunction

  function automatic vec_t irqV(input logic irq_d, input logic irq_e, input logic [7:0] e);
    vec_t v;
    v = busV(1'b1, 1'b1, 1'b1, 3'd5, 4'h0, 3'd0, e);
    v.irq_d = irq_d;
    v.irq_e = irq_e;
    return v;
  endfunction

  // Drive one set of inputs, then advance one rising edge and settle
  task automatic applyStimulus(input logic as_n, input logic uds_n, input logic lds_n,
                               input logic [2:0] fc, input logic [3:0] ah,
                               input logic [2:0] al, input logic irq_d, input logic irq_e);
    AS = as_n; UDS = uds_n; LDS = lds_n; FC = fc;
    ADDR_H = ah; ADDR_L = al; IRQ_DUART = irq_d; IRQ_EXP = irq_e;
    @(posedge CLK);
    #1;
  endtask

  // Compare all outputs against one expected word
  task automatic checkOutput(input string name, input logic [7:0] exp);
    logic [7:0] got;
    got = {DTACK, BERR, VPA, IACK_DUART, IPL, TIMEOUT_FLAG};
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: dtack/berr/vpa/iack/ipl/flag got=%b required=%b", name, got, exp);
    end
  endtask

  initial begin
    // Bus-cycle vectors, one edge per row
    vecs.push_back(busV(1, 1, 1, 3'd5, 4'h0, 3'd0, OFF));
    // RAM write: DTACK one edge after start, release on AS high
    vecs.push_back(busV(0, 1, 0, 3'd5, 4'h8, 3'd0, OFF));
    vecs.push_back(busV(0, 1, 0, 3'd5, 4'h8, 3'd0, eo(0, 1, 1, 1, 3'b111, 0)));
    vecs.push_back(busV(0, 1, 0, 3'd5, 4'h8, 3'd0, eo(0, 1, 1, 1, 3'b111, 0)));
    vecs.push_back(busV(1, 1, 1, 3'd5, 4'h8, 3'd0, OFF));
    // ROM read: DTACK at edge 3
    vecs.push_back(busV(0, 0, 0, 3'd6, 4'h0, 3'd0, OFF));
    vecs.push_back(busV(0, 0, 0, 3'd6, 4'h0, 3'd0, OFF));
    vecs.push_back(busV(0, 0, 0, 3'd6, 4'h0, 3'd0, OFF));
    vecs.push_back(busV(0, 0, 0, 3'd6, 4'h0, 3'd0, eo(0, 1, 1, 1, 3'b111, 0)));
    vecs.push_back(busV(1, 1, 1, 3'd6, 4'h0, 3'd0, OFF));
    // IO access: DTACK at edge 4
    vecs.push_back(busV(0, 1, 0, 3'd5, 4'hC, 3'd0, OFF));
    vecs.push_back(busV(0, 1, 0, 3'd5, 4'hC, 3'd0, OFF));
    vecs.push_back(busV(0, 1, 0, 3'd5, 4'hC, 3'd0, OFF));
    vecs.push_back(busV(0, 1, 0, 3'd5, 4'hC, 3'd0, OFF));
    vecs.push_back(busV(0, 1, 0, 3'd5, 4'hC, 3'd0, eo(0, 1, 1, 1, 3'b111, 0)));
    vecs.push_back(busV(1, 1, 1, 3'd5, 4'hC, 3'd0, OFF));
    // Back-to-back RAM cycle right after return to IDLE
    vecs.push_back(busV(0, 0, 1, 3'd5, 4'hB, 3'd0, OFF));
    vecs.push_back(busV(0, 0, 1, 3'd5, 4'hB, 3'd0, eo(0, 1, 1, 1, 3'b111, 0)));
    vecs.push_back(busV(1, 1, 1, 3'd5, 4'hB, 3'd0, OFF));
    // Aborted ROM cycle, then a clean ROM cycle
    vecs.push_back(busV(0, 0, 0, 3'd6, 4'h0, 3'd0, OFF));
    vecs.push_back(busV(1, 1, 1, 3'd6, 4'h0, 3'd0, OFF));
    vecs.push_back(busV(0, 0, 0, 3'd6, 4'h0, 3'd0, OFF));
    vecs.push_back(busV(0, 0, 0, 3'd6, 4'h0, 3'd0, OFF));
    vecs.push_back(busV(0, 0, 0, 3'd6, 4'h0, 3'd0, OFF));
    vecs.push_back(busV(0, 0, 0, 3'd6, 4'h0, 3'd0, eo(0, 1, 1, 1, 3'b111, 0)));
    vecs.push_back(busV(1, 1, 1, 3'd6, 4'h0, 3'd0, OFF));
    // AS low without data strobes outside CPU space: no cycle
    vecs.push_back(busV(0, 1, 1, 3'd5, 4'h8, 3'd0, OFF));
    vecs.push_back(busV(0, 1, 1, 3'd5, 4'h8, 3'd0, OFF));
    vecs.push_back(busV(1, 1, 1, 3'd5, 4'h8, 3'd0, OFF));
    // DUART IACK: IACK_DUART at start, DTACK at edge 4
    vecs.push_back(busV(0, 1, 1, 3'd7, 4'hF, 3'd5, eo(1, 1, 1, 0, 3'b111, 0)));
    vecs.push_back(busV(0, 1, 1, 3'd7, 4'hF, 3'd5, eo(1, 1, 1, 0, 3'b111, 0)));
    vecs.push_back(busV(0, 1, 1, 3'd7, 4'hF, 3'd5, eo(1, 1, 1, 0, 3'b111, 0)));
    vecs.push_back(busV(0, 1, 1, 3'd7, 4'hF, 3'd5, eo(1, 1, 1, 0, 3'b111, 0)));
    vecs.push_back(busV(0, 1, 1, 3'd7, 4'hF, 3'd5, eo(0, 1, 1, 0, 3'b111, 0)));
    vecs.push_back(busV(1, 1, 1, 3'd7, 4'hF, 3'd5, OFF));
    // EXP IACK: autovector
    vecs.push_back(busV(0, 1, 1, 3'd7, 4'hF, 3'd3, eo(1, 1, 0, 1, 3'b111, 0)));
    vecs.push_back(busV(0, 1, 1, 3'd7, 4'hF, 3'd3, eo(1, 1, 0, 1, 3'b111, 0)));
    vecs.push_back(busV(1, 1, 1, 3'd7, 4'hF, 3'd3, OFF));
    // Spurious IACK: immediate BERR, no timeout flag
    vecs.push_back(busV(0, 1, 1, 3'd7, 4'hF, 3'd6, eo(1, 0, 1, 1, 3'b111, 0)));
    vecs.push_back(busV(0, 1, 1, 3'd7, 4'hF, 3'd6, eo(1, 0, 1, 1, 3'b111, 0)));
    vecs.push_back(busV(1, 1, 1, 3'd7, 4'hF, 3'd6, OFF));
    // Interrupt priority through the two-flop synchroniser
    vecs.push_back(irqV(0, 1, OFF));
    vecs.push_back(irqV(0, 1, OFF));
    vecs.push_back(irqV(0, 1, eo(1, 1, 1, 1, 3'b010, 0)));
    vecs.push_back(irqV(0, 0, eo(1, 1, 1, 1, 3'b010, 0)));
    vecs.push_back(irqV(0, 0, eo(1, 1, 1, 1, 3'b010, 0)));
    vecs.push_back(irqV(0, 0, eo(1, 1, 1, 1, 3'b010, 0)));
    vecs.push_back(irqV(1, 0, eo(1, 1, 1, 1, 3'b010, 0)));
    vecs.push_back(irqV(1, 0, eo(1, 1, 1, 1, 3'b010, 0)));
    vecs.push_back(irqV(1, 0, eo(1, 1, 1, 1, 3'b100, 0)));
    vecs.push_back(irqV(1, 1, eo(1, 1, 1, 1, 3'b100, 0)));
    vecs.push_back(irqV(1, 1, eo(1, 1, 1, 1, 3'b100, 0)));
    vecs.push_back(irqV(1, 1, OFF));

    // Reset with bus idle
    RST = 1'b0;
    applyStimulus(1, 1, 1, 3'd5, 4'h0, 3'd0, 1, 1);
    applyStimulus(1, 1, 1, 3'd5, 4'h0, 3'd0, 1, 1);
    checkOutput("reset", OFF);
    RST = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].as_n, vecs[i].uds_n, vecs[i].lds_n, vecs[i].fc,
                    vecs[i].addr_h, vecs[i].addr_l, vecs[i].irq_d, vecs[i].irq_e);
      checkOutput($sformatf("row%0d", i), vecs[i].exp);
    end

    // Unmapped access: BERR and sticky flag exactly at edge 64
    applyStimulus(0, 1, 0, 3'd5, 4'h4, 3'd0, 1, 1);
    checkOutput("timeout_start", OFF);
    for (int k = 1; k < 64; k++) begin
      applyStimulus(0, 1, 0, 3'd5, 4'h4, 3'd0, 1, 1);
      checkOutput($sformatf("timeout_wait%0d", k), OFF);
    end
    applyStimulus(0, 1, 0, 3'd5, 4'h4, 3'd0, 1, 1);
    checkOutput("timeout_berr", eo(1, 0, 1, 1, 3'b111, 1));
    applyStimulus(1, 1, 1, 3'd5, 4'h4, 3'd0, 1, 1);
    checkOutput("timeout_release", eo(1, 1, 1, 1, 3'b111, 1));

    // Reset in the middle of a DUART IACK cycle
    applyStimulus(0, 1, 1, 3'd7, 4'hF, 3'd5, 1, 1);
    checkOutput("rst_iack_start", eo(1, 1, 1, 0, 3'b111, 1));
    applyStimulus(0, 1, 1, 3'd7, 4'hF, 3'd5, 1, 1);
    checkOutput("rst_iack_wait", eo(1, 1, 1, 0, 3'b111, 1));
    RST = 1'b0;
    applyStimulus(0, 1, 1, 3'd7, 4'hF, 3'd5, 1, 1);
    checkOutput("rst_mid_cycle", OFF);
    RST = 1'b1;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(0, 1, 1, 3'd7, 4'hF, 3'd5, 1, 1);
      checkOutput($sformatf("rst_hold%0d", k), OFF);
    end
    applyStimulus(1, 1, 1, 3'd5, 4'h8, 3'd0, 1, 1);
    checkOutput("rst_as_high", OFF);
    applyStimulus(0, 1, 0, 3'd5, 4'h8, 3'd0, 1, 1);
    checkOutput("rst_new_start", OFF);
    applyStimulus(0, 1, 0, 3'd5, 4'h8, 3'd0, 1, 1);
    checkOutput("rst_new_dtack", eo(0, 1, 1, 1, 3'b111, 0));
    applyStimulus(1, 1, 1, 3'd5, 4'h8, 3'd0, 1, 1);
    checkOutput("rst_new_release", OFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
